boundary_monitor_mr: RTL and testbench

BOUNDARY_MONITOR_MR -- requirements
Module: boundary_monitor_mr

---
 rtl/boundary_monitor_mr.sv | 149 ++++++++++++++
 tb/tb_boundary_monitor_mr.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boundary_monitor_mr.sv
// boundary_monitor_mr
// Watches CPU and DMA write traffic against a set of protected address
// regions. Any hit forces a device reset request that is held for at least
// HOLD_CYCLES cycles and released only once the CPU sits at the reset
// handler. The first offending region and its source are captured sticky,
// together with a saturating count of violation events.
module boundary_monitor_mr #(
   parameter int unsigned       ADDR_W        = 16,
   parameter int unsigned       NUM_REGIONS   = 4,
   parameter logic [ADDR_W-1:0] TCB_BASE      = 16'hA000,
   parameter logic [ADDR_W-1:0] TCB_SIZE      = 16'h4000,
   parameter logic [ADDR_W-1:0] RESET_HANDLER = 16'h0000,
   parameter int unsigned       HOLD_CYCLES   = 4,
   localparam int unsigned      IDX_W         = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_W-1:0]             pc,
   input  logic [ADDR_W-1:0]             data_addr,
   input  logic                          data_en,
   input  logic [ADDR_W-1:0]             dma_addr,
   input  logic                          dma_en,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_min,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_max,
   input  logic [NUM_REGIONS-1:0]        region_en,
   input  logic [NUM_REGIONS-1:0]        region_tcb_exempt,
   input  logic                          violation_clr,
   output logic                          reset,
   output logic                          violation_valid,
   output logic [IDX_W-1:0]              violation_region,
   output logic [1:0]                    violation_src,
   output logic [7:0]                    violation_count
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

   // TCB window bounds, one extra bit so the end address cannot wrap
   localparam logic [ADDR_W:0] TCB_LO = {1'b0, TCB_BASE};
   localparam logic [ADDR_W:0] TCB_HI = {1'b0, TCB_BASE} + {1'b0, TCB_SIZE};

   typedef enum logic {
      ST_RUN,
      ST_KILL
   } state_e;

   state_e                 state_q;
   logic [HOLD_W-1:0]      hold_q;
   logic                   reset_q;
   logic                   valid_q;
   logic [IDX_W-1:0]       region_q;
   logic [1:0]             src_q;
   logic [7:0]             count_q;

   logic                   inside_tcb;
   logic [NUM_REGIONS-1:0] cpu_hit;
   logic [NUM_REGIONS-1:0] dma_hit;
   logic                   viol;
   logic [IDX_W-1:0]       first_idx;
   logic [1:0]             first_src;
   logic                   first_found;

   assign inside_tcb = ({1'b0, pc} >= TCB_LO) && ({1'b0, pc} < TCB_HI);

   // Per-region hit detection; inverted bounds naturally never match
   always_comb begin
      cpu_hit = '0;
      dma_hit = '0;
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
         cpu_hit[i] = data_en && region_en[i]
                      && (data_addr >= region_min[i*ADDR_W +: ADDR_W])
                      && (data_addr <= region_max[i*ADDR_W +: ADDR_W])
                      && !(region_tcb_exempt[i] && inside_tcb);
         dma_hit[i] = dma_en && region_en[i]
                      && (dma_addr >= region_min[i*ADDR_W +: ADDR_W])
                      && (dma_addr <= region_max[i*ADDR_W +: ADDR_W]);
      end
   end

   assign viol = |{cpu_hit, dma_hit};

   // Lowest-index hitting region and which masters hit it
   always_comb begin
      first_idx   = '0;
      first_src   = '0;
      first_found = 1'b0;
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
         if (!first_found && (cpu_hit[i] || dma_hit[i])) begin
            first_idx   = IDX_W'(i);
            first_src   = {dma_hit[i], cpu_hit[i]};
            first_found = 1'b1;
         end
      end
   end

   // RUN/KILL controller with registered reset request and violation record
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_KILL;
         hold_q   <= '0;
         reset_q  <= 1'b1;
         valid_q  <= 1'b0;
         region_q <= '0;
         src_q    <= '0;
         count_q  <= '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (viol) begin
                  state_q <= ST_KILL;
                  reset_q <= 1'b1;
                  hold_q  <= HOLD_RELOAD;
                  if (count_q != '1) begin
                     count_q <= count_q + 8'd1;
                  end
                  if (!valid_q) begin
                     valid_q  <= 1'b1;
                     region_q <= first_idx;
                     src_q    <= first_src;
                  end
               end else if (violation_clr && inside_tcb) begin
                  valid_q  <= 1'b0;
                  region_q <= '0;
                  src_q    <= '0;
                  count_q  <= '0;
               end
            end
            ST_KILL: begin
               reset_q <= 1'b1;
               if (viol) begin
                  hold_q <= HOLD_RELOAD;
               end else if (hold_q != '0) begin
                  hold_q <= hold_q - 1'b1;
               end else if (pc == RESET_HANDLER) begin
                  state_q <= ST_RUN;
                  reset_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign reset            = reset_q;
   assign violation_valid  = valid_q;
   assign violation_region = region_q;
   assign violation_src    = src_q;
   assign violation_count  = count_q;

endmodule

// File: tb/tb_boundary_monitor_mr.sv
// Directed bench for boundary_monitor_mr with a cycle-level reference model.
module tb_boundary_monitor_mr;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] pc = '0;
   logic [15:0] data_addr = '0;
   logic        data_en = 1'b0;
   logic [15:0] dma_addr = '0;
   logic        dma_en = 1'b0;
   logic [63:0] region_min = '0;
   logic [63:0] region_max = '0;
   logic [3:0]  region_en = '0;
   logic [3:0]  region_tcb_exempt = '0;
   logic        violation_clr = 1'b0;
   logic        reset;
   logic        violation_valid;
   logic [1:0]  violation_region;
   logic [1:0]  violation_src;
   logic [7:0]  violation_count;

   int checks = 0;
   int failures = 0;

   boundary_monitor_mr #(
      .ADDR_W(16),
      .NUM_REGIONS(4),
      .TCB_BASE(16'hA000),
      .TCB_SIZE(16'h4000),
      .RESET_HANDLER(16'h0000),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pc(pc),
      .data_addr(data_addr),
      .data_en(data_en),
      .dma_addr(dma_addr),
      .dma_en(dma_en),
      .region_min(region_min),
      .region_max(region_max),
      .region_en(region_en),
      .region_tcb_exempt(region_tcb_exempt),
      .violation_clr(violation_clr),
      .reset(reset),
      .violation_valid(violation_valid),
      .violation_region(violation_region),
      .violation_src(violation_src),
      .violation_count(violation_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_in_tcb(input logic [15:0] p);
      int v;
      v = int'(p);
      return (v >= 'hA000) && (v < 'hA000 + 'h4000);
   endfunction

   function automatic logic [3:0] model_hits(input logic [15:0] a, input logic en,
                                             input bit is_cpu, input logic [15:0] p,
                                             input logic [63:0] mn, input logic [63:0] mx,
                                             input logic [3:0] ren, input logic [3:0] rex);
      logic [3:0] h;
      h = '0;
      for (int i = 0; i < 4; i++) begin
         int lo, hi, ad;
         lo = int'(mn[i*16 +: 16]);
         hi = int'(mx[i*16 +: 16]);
         ad = int'(a);
         h[i] = en && ren[i] && (ad >= lo) && (ad <= hi)
                && !(is_cpu && rex[i] && model_in_tcb(p));
      end
      return h;
   endfunction

   function automatic int model_first(input logic [3:0] h);
      for (int i = 0; i < 4; i++) if (h[i]) return i;
      return 0;
   endfunction

   logic [3:0] m_ch, m_dh;
   logic       m_viol;
   assign m_ch = model_hits(data_addr, data_en, 1'b1, pc, region_min, region_max, region_en, region_tcb_exempt);
   assign m_dh = model_hits(dma_addr, dma_en, 1'b0, pc, region_min, region_max, region_en, region_tcb_exempt);
   assign m_viol = |{m_ch, m_dh};

   // m_age counts clock edges since the most recent violation
   bit m_kill;
   int m_age;
   bit m_valid;
   int m_region;
   int m_src;
   int m_count;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_kill   <= 1'b1;
         m_age    <= HOLD;
         m_valid  <= 1'b0;
         m_region <= 0;
         m_src    <= 0;
         m_count  <= 0;
      end else if (m_viol) begin
         m_kill <= 1'b1;
         m_age  <= 1;
         if (!m_kill) begin
            m_count <= (m_count < 255) ? m_count + 1 : 255;
            if (!m_valid) begin
               m_valid  <= 1'b1;
               m_region <= model_first(m_ch | m_dh);
               m_src    <= 2 * int'(m_dh[model_first(m_ch | m_dh)]) + int'(m_ch[model_first(m_ch | m_dh)]);
            end
         end
      end else if (m_kill) begin
         if (m_age >= HOLD && pc == 16'h0000) m_kill <= 1'b0;
         else if (m_age < 1000) m_age <= m_age + 1;
      end else if (violation_clr && model_in_tcb(pc)) begin
         m_valid  <= 1'b0;
         m_region <= 0;
         m_src    <= 0;
         m_count  <= 0;
      end
   end

   always @(negedge clk) begin
      check("model_reset", 32'(reset), 32'(m_kill));
      check("model_valid", 32'(violation_valid), 32'(m_valid));
      check("model_region", 32'(violation_region), m_region);
      check("model_src", 32'(violation_src), m_src);
      check("model_count", 32'(violation_count), m_count);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_region(input int i, input logic [15:0] lo, input logic [15:0] hi,
                             input logic en, input logic ex);
      region_min[i*16 +: 16] = lo;
      region_max[i*16 +: 16] = hi;
      region_en[i]           = en;
      region_tcb_exempt[i]   = ex;
   endtask

   task automatic recover();
      data_en       = 1'b0;
      dma_en        = 1'b0;
      violation_clr = 1'b0;
      pc            = 16'h0000;
      repeat (HOLD) tick();
      check("recover_reset", 32'(reset), 0);
   endtask

   task automatic clear_info();
      pc            = 16'hA000;
      violation_clr = 1'b1;
      tick();
      violation_clr = 1'b0;
      check("clear_valid", 32'(violation_valid), 0);
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      check("rst_reset", 32'(reset), 1);
      check("rst_valid", 32'(violation_valid), 0);
      check("rst_count", 32'(violation_count), 0);
      tick();
      tick();
      rst = 1'b0;
      check("post_rst_reset", 32'(reset), 1);
      tick();
      check("run_reset", 32'(reset), 0);

      // CPU write into region 0 from outside the TCB
      set_region(0, 16'h0180, 16'h01A5, 1'b1, 1'b0);
      pc = 16'hE000; data_addr = 16'h0190; data_en = 1'b1;
      tick();
      check("v1_reset", 32'(reset), 1);
      check("v1_valid", 32'(violation_valid), 1);
      check("v1_region", 32'(violation_region), 0);
      check("v1_src", 32'(violation_src), 1);
      check("v1_count", 32'(violation_count), 1);
      data_en = 1'b0; pc = 16'h0000;
      for (int k = 0; k < HOLD - 1; k++) begin
         tick();
         check("hold_reset", 32'(reset), 1);
      end
      tick();
      check("release_reset", 32'(reset), 0);

      // Exempt region: CPU write from TCB allowed (and clears info), DMA is not
      set_region(1, 16'h01B0, 16'h0232, 1'b1, 1'b1);
      pc = 16'hA100; data_addr = 16'h01B0; data_en = 1'b1; violation_clr = 1'b1;
      tick();
      check("exempt_reset", 32'(reset), 0);
      check("exempt_clr_valid", 32'(violation_valid), 0);
      check("exempt_clr_count", 32'(violation_count), 0);
      violation_clr = 1'b0; data_en = 1'b0; dma_addr = 16'h01B0; dma_en = 1'b1;
      tick();
      check("dma_reset", 32'(reset), 1);
      check("dma_region", 32'(violation_region), 1);
      check("dma_src", 32'(violation_src), 2);
      recover();

      // Simultaneous hits on regions 0 and 2: lowest index wins, first cause kept
      clear_info();
      set_region(2, 16'h0300, 16'h0310, 1'b1, 1'b0);
      pc = 16'hE000; data_addr = 16'h0180; data_en = 1'b1; dma_addr = 16'h0305; dma_en = 1'b1;
      tick();
      check("multi_region", 32'(violation_region), 0);
      check("multi_src", 32'(violation_src), 1);
      recover();
      pc = 16'hE000; dma_addr = 16'h0305; dma_en = 1'b1;
      tick();
      check("second_region", 32'(violation_region), 0);
      check("second_src", 32'(violation_src), 1);
      check("second_count", 32'(violation_count), 2);
      recover();

      // Violation in KILL while hold counter is 1 reloads the hold
      pc = 16'hE000; data_addr = 16'h0190; data_en = 1'b1;
      tick();
      data_en = 1'b0; pc = 16'h0000;
      tick();
      tick();
      data_en = 1'b1;
      tick();
      data_en = 1'b0;
      check("kill_viol_count", 32'(violation_count), 3);
      for (int k = 0; k < HOLD - 1; k++) begin
         tick();
         check("reload_hold_reset", 32'(reset), 1);
      end
      tick();
      check("reload_release", 32'(reset), 0);
      pc = 16'hE000; violation_clr = 1'b1;
      tick();
      check("clr_outside_valid", 32'(violation_valid), 1);
      check("clr_outside_count", 32'(violation_count), 3);
      pc = 16'hA000;
      tick();
      violation_clr = 1'b0;
      check("clr_inside_valid", 32'(violation_valid), 0);
      check("clr_inside_count", 32'(violation_count), 0);
      check("clr_inside_src", 32'(violation_src), 0);

      // Violation and clear in the same cycle: violation wins
      pc = 16'hA000; violation_clr = 1'b1; data_addr = 16'h0190; data_en = 1'b1;
      tick();
      check("viol_vs_clr_valid", 32'(violation_valid), 1);
      check("viol_vs_clr_count", 32'(violation_count), 1);
      recover();

      // Inverted region never hits; single-address region hits exactly
      set_region(1, 16'h01B0, 16'h0232, 1'b0, 1'b1);
      set_region(3, 16'h0200, 16'h01FF, 1'b1, 1'b0);
      pc = 16'hE000; data_addr = 16'h0200; data_en = 1'b1;
      tick();
      check("inverted_lo", 32'(reset), 0);
      data_addr = 16'h01FF;
      tick();
      check("inverted_hi", 32'(reset), 0);
      data_en = 1'b0;
      clear_info();
      set_region(3, 16'h0400, 16'h0400, 1'b1, 1'b0);
      pc = 16'hE000; data_addr = 16'h0401; data_en = 1'b1;
      tick();
      check("point_miss", 32'(reset), 0);
      data_addr = 16'h0400;
      tick();
      check("point_hit", 32'(reset), 1);
      check("point_region", 32'(violation_region), 3);
      recover();

      // TCB edges for an exempt region
      set_region(1, 16'h01B0, 16'h0232, 1'b1, 1'b1);
      pc = 16'hDFFF; data_addr = 16'h01B0; data_en = 1'b1;
      tick();
      check("tcb_top_exempt", 32'(reset), 0);
      pc = 16'h9FFF;
      tick();
      check("tcb_below_viol", 32'(reset), 1);
      recover();

      // Saturation of the event counter
      repeat (256) begin
         pc = 16'h0000; data_addr = 16'h0190; data_en = 1'b1;
         tick();
         data_en = 1'b0;
         repeat (HOLD) tick();
      end
      check("sat_count", 32'(violation_count), 255);
      check("sat_reset", 32'(reset), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
